// File: rtl/fft_modulus_sink.sv
// ============================================================================
// Module      : fft_modulus_sink
// Description : FFT output sink. Frames checked against FFT_N, then a
//               pipelined floor(sqrt(re^2 + im^2)) is computed for each bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_modulus_sink #(
    parameter int DATA_W = 16,
    parameter int FFT_N  = 128
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    input  logic [DATA_W-1:0] source_real,
    input  logic [DATA_W-1:0] source_imag,
    output logic              data_sop,
    output logic              data_eop,
    output logic              data_valid,
    output logic [31:0]       data_modulus,
    output logic              frame_err
);

    localparam int c_RW = DATA_W + 1;
    localparam int c_L  = DATA_W + 4;
    localparam int c_CW = $clog2(FFT_N);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FFT_N - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_FRAME = 1'b1;

    logic [0:0]      r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic            w_accept, w_sop, w_eop, w_err;
    logic            r_frame_err;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame_err <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_err       = 1'b0;
        if (source_valid) begin
            if (source_sop) begin
                // A sop always opens a fresh frame; a coincident eop is ignored.
                w_accept    = 1'b1;
                w_sop       = 1'b1;
                w_err       = source_eop || (r_state == c_S_FRAME);
                w_cnt_nxt   = c_CNT_ONE;
                w_state_nxt = c_S_FRAME;
            end else if (r_state == c_S_IDLE) begin
                w_err = 1'b1;
            end else begin
                w_accept = 1'b1;
                if (source_eop || (r_cnt == c_CNT_LAST)) begin
                    w_eop       = 1'b1;
                    w_err       = (r_cnt != c_CNT_LAST) || !source_eop;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    // Sideband chain: bit j flags a live sample in datapath stage j.
    logic [c_L:1] r_vld, r_sop, r_eop;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_sop <= '0;
            r_eop <= '0;
        end else begin
            r_vld <= {r_vld[c_L-1:1], w_accept};
            r_sop <= {r_sop[c_L-1:1], w_sop};
            r_eop <= {r_eop[c_L-1:1], w_eop};
        end
    end

    logic signed [DATA_W-1:0]   r_re, r_im;
    logic signed [2*DATA_W-1:0] w_re_x, w_im_x, w_sq_re, w_sq_im;
    logic [2*DATA_W-1:0]        r_sq_re, r_sq_im;
    logic [2*c_RW-1:0]          r_rad [0:c_RW-1];
    logic [c_RW-1:0]            r_rem [1:c_RW-1];
    logic [c_RW-1:0]            r_root [1:c_RW-1];
    logic [c_RW-1:0]            r_root_out;

    assign w_re_x  = (2*DATA_W)'(r_re);
    assign w_im_x  = (2*DATA_W)'(r_im);
    assign w_sq_re = w_re_x * w_re_x;
    assign w_sq_im = w_im_x * w_im_x;

    always_ff @(posedge clk_50m) begin
        if (w_accept) begin
            r_re <= source_real;
            r_im <= source_imag;
        end
        if (r_vld[1]) begin
            r_sq_re <= w_sq_re;
            r_sq_im <= w_sq_im;
        end
        if (r_vld[2]) begin
            r_rad[0] <= {2'b00, r_sq_re} + {2'b00, r_sq_im};
        end
    end

    // Restoring square root: each stage consumes two radicand bits, MSB first.
    for (genvar k = 1; k <= c_RW; k++) begin : g_sqrt
        logic [c_RW-1:0] w_rem_prev, w_root_prev;
        logic [c_RW+1:0] w_rem_sh, w_trial;
        logic            w_ge;

        if (k == 1) begin : g_first
            assign w_rem_prev  = '0;
            assign w_root_prev = '0;
        end else begin : g_rest
            assign w_rem_prev  = r_rem[k-1];
            assign w_root_prev = r_root[k-1];
        end

        assign w_rem_sh = {w_rem_prev, r_rad[k-1][2*c_RW-1 -: 2]};
        assign w_trial  = {w_root_prev, 2'b01};
        assign w_ge     = (w_rem_sh >= w_trial);

        if (k < c_RW) begin : g_mid
            logic [c_RW+1:0] w_diff;
            assign w_diff = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

            always_ff @(posedge clk_50m) begin
                if (r_vld[k+2]) begin
                    r_rad[k]  <= {r_rad[k-1][2*c_RW-3:0], 2'b00};
                    r_rem[k]  <= c_RW'(w_diff);
                    r_root[k] <= c_RW'({w_root_prev, w_ge});
                end
            end
        end else begin : g_last
            always_ff @(posedge clk_50m or posedge rst) begin
                if (rst) begin
                    r_root_out <= '0;
                end else if (r_vld[k+2]) begin
                    r_root_out <= c_RW'({w_root_prev, w_ge});
                end
            end
        end
    end

    assign data_valid   = r_vld[c_L];
    assign data_sop     = r_sop[c_L];
    assign data_eop     = r_eop[c_L];
    assign data_modulus = {{(32-c_RW){1'b0}}, r_root_out};
    assign frame_err    = r_frame_err;

endmodule

`default_nettype wire
